// File: rtl/sipo_word_assembler.sv
// sipo_word_assembler
// Assembles a serial bit stream into WIDTH-bit parallel words. The output word is
// registered and is the load data for a downstream PIPO stage. The first bit of
// each frame can be forced with sin_start. If a partial frame is discarded this way,
// the sticky frame_err flag is set.
// Optional feature: define SIPO_PARITY_EN to append an even-parity bit to every frame.
// That bit is checked, and the result is reported on parity_err together with the word.
module sipo_word_assembler #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic             sin_ready,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             frame_err,
    output logic             parity_err
);

`ifdef SIPO_PARITY_EN
    localparam int FRAME_C = WIDTH + 1;
`else
    localparam int FRAME_C = WIDTH;
`endif
    localparam int            CW     = $clog2(FRAME_C);
    localparam logic [CW-1:0] LAST_C = CW'(FRAME_C - 1);
    localparam logic [CW-1:0] ONE_C  = CW'(1);
    localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Shifts one bit into a data word. The first bit received ends up at the MSB
    // or at the LSB, depending on MSB_FIRST.
    function automatic logic [WIDTH-1:0] shift_in_f(input logic [WIDTH-1:0] d, input logic b);
        if (MSB_FIRST != 0) begin
            return {d[WIDTH-2:0], b};
        end else begin
            return {b, d[WIDTH-1:1]};
        end
    endfunction

    // Even-parity check: 1 when data plus parity bit hold an odd number of ones.
    function automatic logic even_parity_err_f(input logic [WIDTH-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    state_t           state_r, state_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic [WIDTH-1:0] sr_r, sr_nxt_s;
    logic [WIDTH-1:0] word_r, word_nxt_s;
    logic             word_valid_r, word_valid_nxt_s;
    logic             frame_err_r, frame_err_nxt_s;
    logic [WIDTH-1:0] done_word_s;
    logic             accept_s;
    logic             out_free_s;
    logic             sin_ready_s;
`ifdef SIPO_PARITY_EN
    logic             parity_err_r, parity_err_nxt_s;
    logic             hold_par_r, hold_par_nxt_s;
    logic             done_par_s;
`endif

    assign sin_ready_s = rst && (state_r != HOLD);
    assign accept_s    = sin_valid && sin_ready_s;
    assign out_free_s  = !word_valid_r || word_ready;

    // Next-state and datapath decode for the frame assembler FSM.
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        sr_nxt_s         = sr_r;
        word_nxt_s       = word_r;
        frame_err_nxt_s  = frame_err_r;
`ifdef SIPO_PARITY_EN
        parity_err_nxt_s = parity_err_r;
        hold_par_nxt_s   = hold_par_r;
        done_word_s      = sr_r;
        done_par_s       = even_parity_err_f(sr_r, sin);
`else
        done_word_s      = shift_in_f(sr_r, sin);
`endif
        if (word_valid_r && word_ready) begin
            word_valid_nxt_s = 1'b0;
        end else begin
            word_valid_nxt_s = word_valid_r;
        end

        case (state_r)
            IDLE, SHIFT: begin
                if (!accept_s) begin
                    state_nxt_s = state_r;
                end else if (sin_start) begin
                    // Restart: the bit is frame bit 0 and any partial word is dropped.
                    frame_err_nxt_s = frame_err_r | (cnt_r != ZERO_C);
                    sr_nxt_s        = shift_in_f({WIDTH{1'b0}}, sin);
                    cnt_nxt_s       = ONE_C;
                    state_nxt_s     = SHIFT;
                end else if (cnt_r == LAST_C) begin
                    cnt_nxt_s = ZERO_C;
                    if (out_free_s) begin
                        word_nxt_s       = done_word_s;
                        word_valid_nxt_s = 1'b1;
`ifdef SIPO_PARITY_EN
                        parity_err_nxt_s = done_par_s;
`endif
                        sr_nxt_s         = {WIDTH{1'b0}};
                        state_nxt_s      = IDLE;
                    end else begin
                        // Output still occupied: park the finished word in the shift register.
                        sr_nxt_s       = done_word_s;
`ifdef SIPO_PARITY_EN
                        hold_par_nxt_s = done_par_s;
`endif
                        state_nxt_s    = HOLD;
                    end
                end else begin
                    sr_nxt_s    = shift_in_f(sr_r, sin);
                    cnt_nxt_s   = cnt_r + ONE_C;
                    state_nxt_s = SHIFT;
                end
            end
            HOLD: begin
                if (word_ready) begin
                    word_nxt_s       = sr_r;
                    word_valid_nxt_s = 1'b1;
`ifdef SIPO_PARITY_EN
                    parity_err_nxt_s = hold_par_r;
`endif
                    sr_nxt_s         = {WIDTH{1'b0}};
                    state_nxt_s      = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = ZERO_C;
                sr_nxt_s    = {WIDTH{1'b0}};
            end
        endcase
    end

    // State, counter, shift and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            cnt_r        <= ZERO_C;
            sr_r         <= {WIDTH{1'b0}};
            word_r       <= {WIDTH{1'b0}};
            word_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
`ifdef SIPO_PARITY_EN
            parity_err_r <= 1'b0;
            hold_par_r   <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            sr_r         <= sr_nxt_s;
            word_r       <= word_nxt_s;
            word_valid_r <= word_valid_nxt_s;
            frame_err_r  <= frame_err_nxt_s;
`ifdef SIPO_PARITY_EN
            parity_err_r <= parity_err_nxt_s;
            hold_par_r   <= hold_par_nxt_s;
`endif
        end
    end

    assign sin_ready  = sin_ready_s;
    assign word       = word_r;
    assign word_valid = word_valid_r;
    assign frame_err  = frame_err_r;
`ifdef SIPO_PARITY_EN
    assign parity_err = parity_err_r;
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_word_assembler.sv
// Directed bench for sipo_word_assembler. It drives two instances with shared inputs:
// one with MSB-first bit order and one with LSB-first bit order.
module tb_sipo_word_assembler;

    logic       clk = 1'b0;
    logic       rst, sin, sin_valid, sin_start, word_ready;
    logic       m_sin_ready, m_word_valid, m_frame_err, m_parity_err;
    logic       l_sin_ready, l_word_valid, l_frame_err, l_parity_err;
    logic [3:0] m_word, l_word;
    int         n_checks = 0;
    int         n_fail   = 0;

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(1)) dut_msb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
        .sin_ready(m_sin_ready), .word(m_word), .word_valid(m_word_valid),
        .word_ready(word_ready), .frame_err(m_frame_err), .parity_err(m_parity_err)
    );

    sipo_word_assembler #(.WIDTH(4), .MSB_FIRST(0)) dut_lsb (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sin_start(sin_start),
        .sin_ready(l_sin_ready), .word(l_word), .word_valid(l_word_valid),
        .word_ready(word_ready), .frame_err(l_frame_err), .parity_err(l_parity_err)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic st);
        sin       = b;
        sin_start = st;
        sin_valid = 1'b1;
        @(posedge clk);
        #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
        sin       = 1'b0;
    endtask

    // Sends d[3] first. The even-parity bit follows when parity is built in.
    task automatic send_data(input logic [3:0] d);
        for (int i = 3; i >= 0; i--) send_bit(d[i], 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(^d, 1'b0);
`endif
    endtask

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Directed stimulus and checks.
    initial begin
        rst = 1'b0; sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0; word_ready = 1'b1;
        repeat (2) idle_cycle();
        check_eq("rst_word",      m_word, 16'h0);
        check_eq("rst_valid",     m_word_valid, 16'h0);
        check_eq("rst_frame_err", m_frame_err, 16'h0);
        check_eq("rst_par_err",   m_parity_err, 16'h0);
        check_eq("rst_ready_m",   m_sin_ready, 16'h0);
        check_eq("rst_ready_l",   l_sin_ready, 16'h0);
        rst = 1'b1;
        #1;
        check_eq("ready_after_rst", m_sin_ready, 16'h1);

        // Basic word 1,0,1,1 with word_ready high.
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        check_eq("t1_no_early", m_word_valid, 16'h0);
        send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        check_eq("t1_no_early_par", m_word_valid, 16'h0);
        send_bit(1'b1, 1'b0);
`endif
        check_eq("t1_word_m",  m_word, 16'hB);
        check_eq("t1_valid_m", m_word_valid, 16'h1);
        check_eq("t1_word_l",  l_word, 16'hD);
        check_eq("t1_valid_l", l_word_valid, 16'h1);
        check_eq("t1_par_err", m_parity_err, 16'h0);
        idle_cycle();
        check_eq("t1_valid_drop", m_word_valid, 16'h0);
        check_eq("t1_word_keep",  m_word, 16'hB);

        // Back-to-back words, word_ready high.
        send_data(4'h3);
        check_eq("b2b_word1", m_word, 16'h3);
        check_eq("b2b_valid1", m_word_valid, 16'h1);
        send_data(4'hC);
        check_eq("b2b_word2", m_word, 16'hC);
        check_eq("b2b_valid2", m_word_valid, 16'h1);
        idle_cycle();

        // Backpressure: two words with word_ready low.
        word_ready = 1'b0;
        send_data(4'hA);
        check_eq("t2_word_a_m", m_word, 16'hA);
        check_eq("t2_word_a_l", l_word, 16'h5);
        send_data(4'h5);
        check_eq("t2_hold_ready", m_sin_ready, 16'h0);
        check_eq("t2_hold_word",  m_word, 16'hA);
        check_eq("t2_hold_valid", m_word_valid, 16'h1);
        sin = 1'b1; sin_valid = 1'b1; sin_start = 1'b1;
        repeat (2) idle_cycle();
        sin = 1'b0; sin_valid = 1'b0; sin_start = 1'b0;
        check_eq("t2_hold_stable", m_word, 16'hA);
        check_eq("t2_start_ignored", m_frame_err, 16'h0);
        word_ready = 1'b1;
        idle_cycle();
        word_ready = 1'b0;
        check_eq("t2_word_5_m", m_word, 16'h5);
        check_eq("t2_word_5_l", l_word, 16'hA);
        check_eq("t2_valid_5",  m_word_valid, 16'h1);
        check_eq("t2_ready_back", m_sin_ready, 16'h1);
        word_ready = 1'b1;
        idle_cycle();
        check_eq("t2_valid_clear", m_word_valid, 16'h0);

        // Restart in mid-frame sets frame_err.
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        check_eq("t3_no_err_yet", m_frame_err, 16'h0);
        send_bit(1'b1, 1'b1);
        check_eq("t3_frame_err", m_frame_err, 16'h1);
        send_bit(1'b0, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        check_eq("t3_word_m", m_word, 16'h9);
        check_eq("t3_word_l", l_word, 16'h9);
        check_eq("t3_valid",  m_word_valid, 16'h1);
        idle_cycle();
        check_eq("t3_err_sticky", m_frame_err, 16'h1);

        // Reset in mid-frame.
        send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        rst = 1'b0;
        idle_cycle();
        check_eq("t4_err_clr", m_frame_err, 16'h0);
        check_eq("t4_valid",   m_word_valid, 16'h0);
        check_eq("t4_word",    m_word, 16'h0);
        rst = 1'b1;
        send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        check_eq("t4_no_early", m_word_valid, 16'h0);
        send_bit(1'b0, 1'b0);
`ifdef SIPO_PARITY_EN
        send_bit(1'b0, 1'b0);
`endif
        check_eq("t4_word_m", m_word, 16'h6);
        check_eq("t4_word_l", l_word, 16'h6);
        check_eq("t4_valid2", m_word_valid, 16'h1);
        idle_cycle();

`ifdef SIPO_PARITY_EN
        // Parity checking: a wrong parity bit, then a correct one.
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check_eq("t5_par_bad",  m_parity_err, 16'h1);
        check_eq("t5_word_bad", m_word, 16'hB);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("t5_par_ok",   m_parity_err, 16'h0);
        check_eq("t5_word_ok",  m_word, 16'hB);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
